mem_arbiter: RTL and testbench

//  Shares the single-port 256x8 RAM between two requesters: port A (fetch) and port B (datapath).

---
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between requester A (fetch) and
// requester B (datapath). Each access runs IDLE -> ACCESS -> ACK, three cycles.
// All outputs are registered.
//
// Ports:
//   clock, reset                  rising-edge clock, async active-low reset
//   a_req/a_wr/a_addr/a_wdata     requester A access request
//   a_ack                         one-cycle completion pulse for A
//   b_req/b_wr/b_addr/b_wdata     requester B access request
//   b_ack                         one-cycle completion pulse for B
//   rdata                         data of the last completed read
//   mem_addr/mem_data/mem_wr      RAM address, write data, write enable
//   mem_cs                        RAM chip select, active-low
//   mem_o                         RAM read data (combinational)
module mem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned FAIR   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wr,
  output logic              mem_cs,
  input  logic [DATA_W-1:0] mem_o
);

  typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

  state_e state_q;
  // Last granted requester; also identifies the current winner from grant to ack.
  logic   last_b_q;
  logic   pick_b;

  // Winner selection, only consulted in StIdle when some request is present.
  always_comb begin
    pick_b = 1'b0;
    if (b_req && !a_req) begin
      pick_b = 1'b1;
    end else if (a_req && b_req && (FAIR != 0)) begin
      pick_b = !last_b_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      last_b_q <= 1'b1;  // A wins the first tie
      mem_cs   <= 1'b1;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      rdata    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (a_req || b_req) begin
            mem_addr <= pick_b ? b_addr  : a_addr;
            mem_data <= pick_b ? b_wdata : a_wdata;
            mem_wr   <= pick_b ? b_wr    : a_wr;
            mem_cs   <= 1'b0;
            last_b_q <= pick_b;
            state_q  <= StAccess;
          end
        end
        StAccess: begin
          if (!mem_wr) begin
            rdata <= mem_o;
          end
          mem_cs  <= 1'b1;
          mem_wr  <= 1'b0;
          a_ack   <= !last_b_q;
          b_ack   <= last_b_q;
          state_q <= StAck;
        end
        StAck: begin
          a_ack   <= 1'b0;
          b_ack   <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: checks mem_arbiter against a transaction-level model.
// Two DUTs (round-robin and fixed priority) share stimulus; sel picks which
// one is observed. Each DUT has its own RAM array.
module tb_mem_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       a_req = 1'b0, a_wr = 1'b0, b_req = 1'b0, b_wr = 1'b0;
  logic [7:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
  logic       sel = 1'b0;  // 0: observe FAIR=1 DUT, 1: observe FAIR=0 DUT

  logic       f_a_ack, f_b_ack, f_mem_wr, f_mem_cs;
  logic [7:0] f_rdata, f_mem_addr, f_mem_data, f_mem_o;
  logic       p_a_ack, p_b_ack, p_mem_wr, p_mem_cs;
  logic [7:0] p_rdata, p_mem_addr, p_mem_data, p_mem_o;

  logic [7:0] ram_f [256];
  logic [7:0] ram_p [256];
  logic [7:0] mm    [256];

  assign f_mem_o = (!f_mem_cs && !f_mem_wr) ? ram_f[f_mem_addr] : 8'h00;
  assign p_mem_o = (!p_mem_cs && !p_mem_wr) ? ram_p[p_mem_addr] : 8'h00;

  logic       o_a_ack, o_b_ack, o_mem_wr, o_mem_cs;
  logic [7:0] o_rdata, o_mem_addr, o_mem_data;
  assign o_a_ack    = sel ? p_a_ack    : f_a_ack;
  assign o_b_ack    = sel ? p_b_ack    : f_b_ack;
  assign o_mem_wr   = sel ? p_mem_wr   : f_mem_wr;
  assign o_mem_cs   = sel ? p_mem_cs   : f_mem_cs;
  assign o_rdata    = sel ? p_rdata    : f_rdata;
  assign o_mem_addr = sel ? p_mem_addr : f_mem_addr;
  assign o_mem_data = sel ? p_mem_data : f_mem_data;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .FAIR(1)) u_fair (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(f_a_ack),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(f_b_ack),
    .rdata(f_rdata), .mem_addr(f_mem_addr), .mem_data(f_mem_data), .mem_wr(f_mem_wr),
    .mem_cs(f_mem_cs), .mem_o(f_mem_o)
  );

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .FAIR(0)) u_prio (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(p_a_ack),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(p_b_ack),
    .rdata(p_rdata), .mem_addr(p_mem_addr), .mem_data(p_mem_data), .mem_wr(p_mem_wr),
    .mem_cs(p_mem_cs), .mem_o(p_mem_o)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Transaction-level model: an access granted at edge g is acked during the
  // cycle after edge g+1 and the arbiter can grant again at edge g+3.
  int         n = 0;
  int         grant_n = -10;
  int         free_at = 0;
  logic       win_b = 1'b0;
  logic       last_b = 1'b1;
  logic       lat_wr = 1'b0;
  logic [7:0] lat_addr = '0, lat_data = '0;
  logic [7:0] exp_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_reset();
    grant_n   = -10;
    free_at   = 0;
    last_b    = 1'b1;
    exp_rdata = 8'h00;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'(i) ^ 8'hA5;
      if (i == 255) v = 8'hC3;
      ram_f[i] = v;
      ram_p[i] = v;
      mm[i]    = v;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (!f_mem_cs && f_mem_wr) ram_f[f_mem_addr] = f_mem_data;
    if (!p_mem_cs && p_mem_wr) ram_p[p_mem_addr] = p_mem_data;
    n++;
    if (!reset) begin
      model_reset();
    end else begin
      if (n == grant_n + 1) begin
        if (lat_wr) mm[lat_addr] = lat_data;
        else        exp_rdata = mm[lat_addr];
      end
      if (n >= free_at && (a_req || b_req)) begin
        if (a_req && b_req) win_b = sel ? 1'b0 : !last_b;
        else                win_b = b_req;
        last_b   = win_b;
        grant_n  = n;
        free_at  = n + 3;
        lat_wr   = win_b ? b_wr    : a_wr;
        lat_addr = win_b ? b_addr  : a_addr;
        lat_data = win_b ? b_wdata : a_wdata;
      end
    end
    #1;
    chk("a_ack", 32'(o_a_ack), 32'(n == grant_n + 1 && !win_b));
    chk("b_ack", 32'(o_b_ack), 32'(n == grant_n + 1 && win_b));
    chk("mem_cs", 32'(o_mem_cs), 32'(n != grant_n));
    chk("rdata", 32'(o_rdata), 32'(exp_rdata));
    if (!o_mem_cs) begin
      chk("mem_addr", 32'(o_mem_addr), 32'(lat_addr));
      chk("mem_wr", 32'(o_mem_wr), 32'(lat_wr));
      if (lat_wr) chk("mem_data", 32'(o_mem_data), 32'(lat_data));
    end else begin
      chk("mem_wr_idle", 32'(o_mem_wr), 32'h0);
    end
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       ar, aw;
    logic [7:0] aa, ad;
    logic       br, bw;
    logic [7:0] ba, bd;
    logic       ea, eb, ecs, ewr;
    logic [7:0] erd;
  } vec_t;

  function automatic vec_t mk(input logic ar, input logic aw, input logic [7:0] aa,
                              input logic [7:0] ad, input logic br, input logic bw,
                              input logic [7:0] ba, input logic [7:0] bd, input logic ea,
                              input logic eb, input logic ecs, input logic ewr,
                              input logic [7:0] erd);
    vec_t v;
    v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
    v.br = br; v.bw = bw; v.ba = ba; v.bd = bd;
    v.ea = ea; v.eb = eb; v.ecs = ecs; v.ewr = ewr; v.erd = erd;
    return v;
  endfunction

  task automatic drive_random();
    if (a_req && n == grant_n + 2 && !win_b) a_req = 1'($urandom_range(0, 1));
    else if (!a_req) a_req = ($urandom_range(0, 2) == 0);
    if (b_req && n == grant_n + 2 && win_b) b_req = 1'($urandom_range(0, 1));
    else if (!b_req) b_req = ($urandom_range(0, 2) == 0);
    a_wr    = 1'($urandom_range(0, 1));
    b_wr    = 1'($urandom_range(0, 1));
    a_addr  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
    b_addr  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
    a_wdata = 8'($urandom_range(0, 255));
    b_wdata = 8'($urandom_range(0, 255));
  endtask

  vec_t tab[21];
  int   acnt, bcnt;

  initial begin
    tab[0]  = mk(1'b1, 1'b1, 8'h10, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    tab[1]  = mk(1'b1, 1'b1, 8'h10, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tab[2]  = mk(1'b1, 1'b1, 8'h10, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    tab[3]  = mk(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tab[4]  = mk(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A);
    tab[5]  = mk(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A);
    tab[6]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A);
    tab[7]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'hC3);
    tab[8]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC3);
    tab[9]  = mk(1'b1, 1'b1, 8'h30, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3);
    tab[10] = mk(1'b1, 1'b1, 8'h30, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC3);
    tab[11] = mk(1'b1, 1'b1, 8'h30, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC3);
    // Both held: A was last, so B, A, B.
    tab[12] = mk(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3);
    tab[13] = mk(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA7);
    tab[14] = mk(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA7);
    tab[15] = mk(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA7);
    tab[16] = mk(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA4);
    tab[17] = mk(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA4);
    tab[18] = mk(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA4);
    tab[19] = mk(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA7);
    tab[20] = mk(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA7);

    init_mem();
    model_reset();

    // Reset held with a request pending.
    a_req = 1'b1; a_addr = 8'h10;
    tick();
    tick();
    chk("rst_cs", 32'(o_mem_cs), 32'h1);
    chk("rst_ack", 32'({o_a_ack, o_b_ack}), 32'h0);
    chk("rst_rdata", 32'(o_rdata), 32'h0);
    chk("rst_addr", 32'(o_mem_addr), 32'h0);
    chk("rst_wr", 32'(o_mem_wr), 32'h0);
    reset = 1'b1;
    tick();
    chk("rel_cs", 32'(o_mem_cs), 32'h0);
    // Abort that access mid-ACCESS.
    #2;
    assert_reset();
    a_req = 1'b0;
    #1;
    chk("abort_cs_async", 32'(o_mem_cs), 32'h1);
    tick();
    reset = 1'b1;

    // Directed table on the round-robin DUT.
    for (int i = 0; i < 21; i++) begin
      a_req = tab[i].ar; a_wr = tab[i].aw; a_addr = tab[i].aa; a_wdata = tab[i].ad;
      b_req = tab[i].br; b_wr = tab[i].bw; b_addr = tab[i].ba; b_wdata = tab[i].bd;
      tick();
      chk($sformatf("tab%0d_a_ack", i), 32'(o_a_ack), 32'(tab[i].ea));
      chk($sformatf("tab%0d_b_ack", i), 32'(o_b_ack), 32'(tab[i].eb));
      chk($sformatf("tab%0d_cs", i), 32'(o_mem_cs), 32'(tab[i].ecs));
      chk($sformatf("tab%0d_wr", i), 32'(o_mem_wr), 32'(tab[i].ewr));
      chk($sformatf("tab%0d_rdata", i), 32'(o_rdata), 32'(tab[i].erd));
    end
    a_req = 1'b0; b_req = 1'b0;
    tick();

    // B write to 0x20 cut off by reset during ACCESS.
    b_req = 1'b1; b_wr = 1'b1; b_addr = 8'h20; b_wdata = 8'h77;
    tick();
    chk("abort_b_granted", 32'(o_mem_cs), 32'h0);
    #2;
    assert_reset();
    b_req = 1'b0;
    #1;
    chk("abort_b_cs_async", 32'(o_mem_cs), 32'h1);
    tick();
    chk("abort_b_no_ack", 32'(o_b_ack), 32'h0);
    reset = 1'b1;
    b_req = 1'b1; b_wr = 1'b0;
    tick();
    tick();
    chk("abort_b_ack", 32'(o_b_ack), 32'h1);
    chk("abort_b_old_data", 32'(o_rdata), 32'h85);
    tick();
    b_req = 1'b0;
    tick();

    // Fixed priority: B starves while A keeps requesting.
    sel = 1'b1;
    init_mem();
    assert_reset();
    tick();
    reset = 1'b1;
    acnt = 0; bcnt = 0;
    a_req = 1'b1; a_wr = 1'b0; a_addr = 8'h03;
    b_req = 1'b1; b_wr = 1'b0; b_addr = 8'h04;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (o_a_ack) acnt++;
      if (o_b_ack) bcnt++;
    end
    chk("prio_a_acks", 32'(acnt), 32'd5);
    chk("prio_b_acks", 32'(bcnt), 32'd0);
    a_req = 1'b0; b_req = 1'b0;
    tick();

    // Random traffic against the model, both arbitration modes.
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      init_mem();
      a_req = 1'b0; b_req = 1'b0;
      assert_reset();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 600; i++) begin
        drive_random();
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
